// File: rtl/demux_stream.sv
// ============================================================================
// Module   : demux_stream
// Brief    : Registered 1-to-N valid/ready stream demux with packet-locked
//            routing, invalid-channel packet dropping and a drop counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_stream #(
    parameter  int DATA_W = 8,
    parameter  int N_CH   = 8,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    input  logic [SEL_W-1:0]       s_sel,
    input  logic                   s_last,
    output logic [N_CH-1:0]        m_valid,
    input  logic [N_CH-1:0]        m_ready,
    output logic [N_CH*DATA_W-1:0] m_data,
    output logic [N_CH-1:0]        m_last,
    output logic [7:0]             drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_lock_ch;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;
    logic [SEL_W-1:0]    r_out_ch;
    logic [7:0]          r_drop_cnt;

    logic [N_CH-1:0]     w_ch_hit;
    logic                w_out_ready;
    logic                w_accept;
    logic                w_sel_ok;
    logic                w_route;
    logic [SEL_W-1:0]    w_route_ch;
    logic                w_lock_load;
    logic                w_drop_pkt;

    // Select codes at or above N_CH only exist when N_CH is not a power of two.
    if ((1 << SEL_W) == N_CH) begin : g_sel_full
        assign w_sel_ok = 1'b1;
    end else begin : g_sel_partial
        assign w_sel_ok = (32'(s_sel) < N_CH);
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        assign w_ch_hit[k]                 = (r_out_ch == SEL_W'(k));
        assign m_valid[k]                  = r_out_valid & w_ch_hit[k];
        assign m_data[k*DATA_W +: DATA_W]  = m_valid[k] ? r_out_data : '0;
        assign m_last[k]                   = m_valid[k] & r_out_last;
    end

    // Only the ready of the lane currently holding the beat matters.
    assign w_out_ready = |(m_valid & m_ready);
    assign s_ready     = (r_state == ST_DROP) || !r_out_valid || w_out_ready;
    assign w_accept    = s_valid & s_ready;
    assign drop_cnt    = r_drop_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_route     = 1'b0;
        w_route_ch  = s_sel;
        w_lock_load = 1'b0;
        w_drop_pkt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_sel_ok) begin
                        w_route = 1'b1;
                        if (!s_last) begin
                            w_lock_load = 1'b1;
                            w_state_nxt = ST_LOCK;
                        end
                    end else begin
                        w_drop_pkt = 1'b1;
                        if (!s_last) begin
                            w_state_nxt = ST_DROP;
                        end
                    end
                end
            end
            ST_LOCK: begin
                w_route_ch = r_lock_ch;
                if (w_accept) begin
                    w_route = 1'b1;
                    if (s_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (w_accept && s_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_lock_load) begin
                r_lock_ch <= s_sel;
            end
        end
    end

    // A new beat may load in the same cycle the held one retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_route) begin
            r_out_valid <= 1'b1;
            r_out_data  <= s_data;
            r_out_last  <= s_last;
            r_out_ch    <= w_route_ch;
        end else if (w_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop_pkt && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_demux_stream.sv
// ============================================================================
// Module   : tb_demux_stream
// Brief    : Directed scoreboard bench for demux_stream (8- and 6-channel).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_demux_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  s_data;
    logic [2:0]  s_sel;
    logic        s_last;

    logic        s_valid8, s_ready8;
    logic [7:0]  m_valid8, m_ready8, m_last8, drop_cnt8;
    logic [63:0] m_data8;

    logic        s_valid6, s_ready6;
    logic [5:0]  m_valid6, m_ready6, m_last6;
    logic [47:0] m_data6;
    logic [7:0]  drop_cnt6;

    demux_stream #(.DATA_W(8), .N_CH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data),
        .s_sel(s_sel), .s_last(s_last),
        .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8),
        .m_last(m_last8), .drop_cnt(drop_cnt8)
    );

    demux_stream #(.DATA_W(8), .N_CH(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid6), .s_ready(s_ready6), .s_data(s_data),
        .s_sel(s_sel), .s_last(s_last),
        .m_valid(m_valid6), .m_ready(m_ready6), .m_data(m_data6),
        .m_last(m_last6), .drop_cnt(drop_cnt6)
    );

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Retired beats on the 8-channel instance are matched against the queue.
    always @(negedge clk) begin : mon8
        logic [63:0] busy_mask;
        exp_t        e;
        busy_mask = '0;
        for (int k = 0; k < 8; k++) begin
            if (m_valid8[k]) busy_mask[k*8 +: 8] = 8'hFF;
        end
        check("onehot", 64'($countones(m_valid8) > 1), 64'd0);
        check("idle_lane_zero", m_data8 & ~busy_mask, 64'd0);
        check("idle_last_zero", 64'(m_last8 & ~m_valid8), 64'd0);
        for (int k = 0; k < 8; k++) begin
            if (m_valid8[k] && m_ready8[k]) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat_ch", 64'(k), 64'hFF);
                end else begin
                    e = sb_q.pop_front();
                    check("beat", 64'({3'(k), m_data8[k*8 +: 8], m_last8[k]}), 64'(e));
                end
            end
        end
    end

    // Drives one beat just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input bit to6, input logic [7:0] d, input logic [2:0] sel,
                             input bit last, input int exp_ch, output int waits);
        logic rdy;
        s_data = d;
        s_sel  = sel;
        s_last = last;
        if (to6) s_valid6 = 1'b1;
        else     s_valid8 = 1'b1;
        waits = 0;
        rdy   = 1'b0;
        forever begin
            @(negedge clk);
            rdy = to6 ? s_ready6 : s_ready8;
            if (rdy) break;
            waits++;
            if (waits >= 50) break;
            @(posedge clk);
        end
        if (!rdy) check("accept_timeout", 64'(waits), 64'd0);
        else if (exp_ch >= 0) sb_q.push_back(exp_t'({3'(exp_ch), d, last}));
        @(posedge clk);
        #1;
        s_valid6 = 1'b0;
        s_valid8 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w;
        rst_n    = 1'b0;
        s_valid8 = 1'b0;
        s_valid6 = 1'b0;
        s_data   = 8'd0;
        s_sel    = 3'd0;
        s_last   = 1'b0;
        m_ready8 = 8'hFF;
        m_ready6 = 6'h3F;

        @(negedge clk);
        check("rst_m_valid", 64'(m_valid8), 64'd0);
        check("rst_m_data", m_data8, 64'd0);
        check("rst_m_last", 64'(m_last8), 64'd0);
        check("rst_s_ready", 64'(s_ready8), 64'd1);
        check("rst_drop_cnt", 64'(drop_cnt8), 64'd0);
        check("rst_m_valid6", 64'(m_valid6), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat packets to every channel, one-cycle latency.
        for (int k = 0; k < 8; k++) begin
            send_beat(1'b0, 8'hA0 + 8'(k), 3'(k), 1'b1, k, w);
            @(negedge clk);
            check("single_valid", 64'(m_valid8), 64'(8'h01 << k));
            check("single_last", 64'(m_last8), 64'(8'h01 << k));
            check("single_lane", m_data8, 64'({56'd0, 8'hA0 + 8'(k)}) << (8 * k));
            @(posedge clk);
            #1;
        end

        // Locked 4-beat packet ignores s_sel after the first beat.
        send_beat(1'b0, 8'h30, 3'd3, 1'b0, 3, w);
        send_beat(1'b0, 8'h31, 3'd5, 1'b0, 3, w);
        send_beat(1'b0, 8'h32, 3'd5, 1'b0, 3, w);
        send_beat(1'b0, 8'h33, 3'd5, 1'b1, 3, w);
        send_beat(1'b0, 8'h34, 3'd5, 1'b1, 5, w);
        @(negedge clk);
        check("unlock_ch5", 64'(m_valid8), 64'h20);
        @(posedge clk);
        #1;

        // Backpressure on channel 2 for three cycles.
        m_ready8 = 8'hFB;
        send_beat(1'b0, 8'h21, 3'd2, 1'b0, 2, w);
        s_data   = 8'h22;
        s_sel    = 3'd0;
        s_last   = 1'b1;
        s_valid8 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_s_ready", 64'(s_ready8), 64'd0);
            check("bp_valid", 64'(m_valid8), 64'h04);
            check("bp_hold", 64'(m_data8[23:16]), 64'h21);
            @(posedge clk);
            #1;
        end
        m_ready8 = 8'hFF;
        @(negedge clk);
        check("bp_release", 64'(s_ready8), 64'd1);
        sb_q.push_back(exp_t'({3'd2, 8'h22, 1'b1}));
        @(posedge clk);
        #1;
        s_valid8 = 1'b0;

        // Back-to-back: ch1 two beats then ch4 one beat, no bubble.
        s_data = 8'h41; s_sel = 3'd1; s_last = 1'b0; s_valid8 = 1'b1;
        @(negedge clk);
        check("b2b_ready0", 64'(s_ready8), 64'd1);
        sb_q.push_back(exp_t'({3'd1, 8'h41, 1'b0}));
        @(posedge clk);
        #1;
        s_data = 8'h42; s_sel = 3'd7; s_last = 1'b1;
        @(negedge clk);
        check("b2b_ready1", 64'(s_ready8), 64'd1);
        check("b2b_out0", 64'(m_valid8), 64'h02);
        sb_q.push_back(exp_t'({3'd1, 8'h42, 1'b1}));
        @(posedge clk);
        #1;
        s_data = 8'h43; s_sel = 3'd4; s_last = 1'b1;
        @(negedge clk);
        check("b2b_ready2", 64'(s_ready8), 64'd1);
        check("b2b_out1", 64'(m_valid8), 64'h02);
        sb_q.push_back(exp_t'({3'd4, 8'h43, 1'b1}));
        @(posedge clk);
        #1;
        s_valid8 = 1'b0;
        @(negedge clk);
        check("b2b_out2", 64'(m_valid8), 64'h10);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a locked packet.
        m_ready8 = 8'h00;
        send_beat(1'b0, 8'h50, 3'd1, 1'b0, 1, w);
        #1 rst_n = 1'b0;
        #1;
        check("arst_m_valid", 64'(m_valid8), 64'd0);
        check("arst_m_data", m_data8, 64'd0);
        check("arst_m_last", 64'(m_last8), 64'd0);
        check("arst_s_ready", 64'(s_ready8), 64'd1);
        sb_q.delete();
        #1 rst_n = 1'b1;
        m_ready8 = 8'hFF;
        @(posedge clk);
        #1;
        send_beat(1'b0, 8'h66, 3'd6, 1'b1, 6, w);
        @(negedge clk);
        check("arst_fresh_ch6", 64'(m_valid8), 64'h40);
        check("arst_fresh_data", 64'(m_data8[55:48]), 64'h66);
        @(posedge clk);
        #1;

        // Six-channel instance: invalid select drops whole packets, even under backpressure.
        m_ready6 = 6'h00;
        for (int b = 0; b < 3; b++) begin
            send_beat(1'b1, 8'h70 + 8'(b), 3'd7, (b == 2), -1, w);
            check("drop_no_wait", 64'(w), 64'd0);
            check("drop_no_valid", 64'(m_valid6), 64'd0);
            check("drop_no_data", 64'(m_data6), 64'd0);
        end
        check("drop_cnt_one", 64'(drop_cnt6), 64'd1);
        m_ready6 = 6'h3F;
        for (int i = 0; i < 256; i++) begin
            send_beat(1'b1, 8'h80, 3'(6 + (i % 2)), 1'b1, -1, w);
        end
        check("drop_cnt_sat", 64'(drop_cnt6), 64'd255);
        send_beat(1'b1, 8'h11, 3'd5, 1'b1, -1, w);
        @(negedge clk);
        check("ch6_valid_route", 64'(m_valid6), 64'h20);
        check("ch6_valid_data", 64'(m_data6[47:40]), 64'h11);
        check("drop_cnt8_zero", 64'(drop_cnt8), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
